// File: rtl/spi_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_bank_pkg
// Shared types and sizing helpers for the SPI register bank.
//   state_t       : frame FSM state (IDLE, HDR, DATA)
//   calc_hdr_w    : header width  = rw bit + address field
//   calc_frame_w  : frame width   = header + one data word
//   calc_cnt_w    : bit-counter width, able to hold FRAME_W+1 (saturation value)
// ---------------------------------------------------------------------------
package spi_reg_bank_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   function automatic int calc_hdr_w(input int addr_w);
      return 1 + addr_w;
   endfunction

   function automatic int calc_frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

   function automatic int calc_cnt_w(input int addr_w, input int data_w);
      return $clog2(1 + addr_w + data_w + 2);
   endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for one asynchronous SPI pin plus a history flop used
// for edge detection. Edges are reported between the second sync flop and the
// history flop, so o_rise/o_fall are single-clk pulses aligned with o_sync.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   i_async   : asynchronous pin input
//   o_sync    : synchronised level (sync2)
//   o_rise    : one-clk pulse on a synchronised rising edge
//   o_fall    : one-clk pulse on a synchronised falling edge
// Parameter RST_VAL sets the reset level of all three flops.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_hist;

   // Synchroniser chain plus history flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= RST_VAL;
         r_sync2 <= RST_VAL;
         r_hist  <= RST_VAL;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign o_sync = r_sync2;
   assign o_rise = r_sync2 & ~r_hist;
   assign o_fall = ~r_sync2 & r_hist;

endmodule

// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
// SPI mode-0 peripheral exposing NUM_REGS registers of DATA_W bits.
// Frame (MSB first): rw (1 = write), addr[ADDR_W-1:0], data[DATA_W-1:0].
// Writes commit when ncs rises after exactly FRAME_W bits to a valid address;
// reads return reg[addr] on cipo during the data phase (zero if out of range).
// A frame whose bit count is not FRAME_W produces a one-clk frame_err_o pulse.
//
// Optional feature, macro SPI_REG_BANK_BURST_EN: every completed data word
// commits at once and the address auto-increments (wrapping to 0); reads
// reload from the next address after each word. At ncs rise a partial
// trailing word or a frame shorter than FRAME_W flags frame_err_o.
//
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   sclk, ncs    : SPI clock and active-low chip select (asynchronous)
//   copi         : SPI controller-out data (asynchronous)
//   cipo         : SPI peripheral-out data
//   cipo_oe      : tri-state enable for cipo (data phase of a read)
//   regs_o       : flat register vector, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse_o   : one-clk pulse on bit i when reg i is written
//   frame_err_o  : one-clk pulse on a malformed frame
//   busy_o       : high while a frame is in progress
// Requires f_clk >= 8 x f_sclk.
// ---------------------------------------------------------------------------
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int                NUM_REGS  = 8,
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 7,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         ncs,
   input  logic                         copi,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [NUM_REGS-1:0]          wr_pulse_o,
   output logic                         frame_err_o,
   output logic                         busy_o
);

   localparam int              HDR_W   = calc_hdr_w(ADDR_W);
   localparam int              FRAME_W = calc_frame_w(ADDR_W, DATA_W);
   localparam int              CNT_W   = calc_cnt_w(ADDR_W, DATA_W);
   localparam logic [ADDR_W:0] LP_NUM  = (ADDR_W+1)'(NUM_REGS);

   // Synchronised pin views
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_unused_sclk_sync;
   logic w_ncs_sync;
   logic w_ncs_rise;
   logic w_ncs_fall;
   logic w_copi;
   logic w_unused_copi_rise;
   logic w_unused_copi_fall;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .i_async (sclk),
      .o_sync  (w_unused_sclk_sync),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
      .clk     (clk),
      .rst     (rst),
      .i_async (ncs),
      .o_sync  (w_ncs_sync),
      .o_rise  (w_ncs_rise),
      .o_fall  (w_ncs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
      .clk     (clk),
      .rst     (rst),
      .i_async (copi),
      .o_sync  (w_copi),
      .o_rise  (w_unused_copi_rise),
      .o_fall  (w_unused_copi_fall)
   );

   // Frame state
   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [HDR_W-2:0]    r_hdr;
   logic [DATA_W-1:0]   r_data;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_tx;
   logic                r_cipo;
   logic                r_cipo_oe;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_pulse;
   logic                r_frame_err;
   logic [1:0]          r_flush;
   logic                r_armed;

   logic [HDR_W-1:0]    w_hdr;
   logic                w_addr_ok;

`ifdef SPI_REG_BANK_BURST_EN
   localparam int           WCNT_W  = $clog2(DATA_W);
   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_REGS - 1);
   logic [WCNT_W-1:0]   r_wcnt;
   logic                r_word_done;
   logic [ADDR_W-1:0]   w_addr_next;

   assign w_addr_next = (r_addr == LP_LAST) ? '0 : (r_addr + ADDR_W'(1));
`endif

   // Full header as it stands once the current copi bit is appended
   assign w_hdr     = {r_hdr, w_copi};
   assign w_addr_ok = ({1'b0, r_addr} < LP_NUM);

   // Read mux; addresses past the last register read as zero
   function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) begin
            v = r_regs[i];
         end
      end
      return v;
   endfunction

   // After reset the ncs synchroniser holds its reset value, not the pin.
   // Frames are only accepted once a real high level on ncs has been seen,
   // so a frame interrupted by reset is ignored until ncs goes high then low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush <= 2'd0;
         r_armed <= 1'b0;
      end else begin
         if (r_flush != 2'd3) begin
            r_flush <= r_flush + 2'd1;
         end
         if ((r_flush == 2'd3) && w_ncs_sync) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Frame FSM, register array and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_hdr       <= '0;
         r_data      <= '0;
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_tx        <= '0;
         r_cipo      <= 1'b0;
         r_cipo_oe   <= 1'b0;
         r_wr_pulse  <= '0;
         r_frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= RESET_VAL;
         end
`ifdef SPI_REG_BANK_BURST_EN
         r_wcnt      <= '0;
         r_word_done <= 1'b0;
`endif
      end else begin
         r_wr_pulse  <= '0;
         r_frame_err <= 1'b0;
`ifdef SPI_REG_BANK_BURST_EN
         r_word_done <= 1'b0;
         // A word completed last clk: r_data now holds all of it
         if (r_word_done) begin
            if (r_rw && w_addr_ok) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (r_addr == ADDR_W'(i)) begin
                     r_regs[i]     <= r_data;
                     r_wr_pulse[i] <= 1'b1;
                  end
               end
            end
            if (w_addr_ok) begin
               r_addr <= w_addr_next;
            end
            if (!r_rw) begin
               r_tx <= rd_reg(w_addr_next);
            end
         end
`endif
         case (r_state)
            IDLE: begin
               if (w_ncs_fall && r_armed) begin
                  r_state <= HDR;
                  r_cnt   <= '0;
                  r_hdr   <= '0;
                  r_data  <= '0;
               end
            end
            HDR, DATA: begin
               if (w_ncs_rise) begin
                  r_state   <= IDLE;
                  r_cipo    <= 1'b0;
                  r_cipo_oe <= 1'b0;
`ifdef SPI_REG_BANK_BURST_EN
                  if ((r_cnt < CNT_W'(FRAME_W)) || (r_wcnt != '0)) begin
                     r_frame_err <= 1'b1;
                  end
`else
                  if (r_cnt != CNT_W'(FRAME_W)) begin
                     r_frame_err <= 1'b1;
                  end else if (r_rw && w_addr_ok) begin
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (r_addr == ADDR_W'(i)) begin
                           r_regs[i]     <= r_data;
                           r_wr_pulse[i] <= 1'b1;
                        end
                     end
                  end
`endif
               end else if (r_state == HDR) begin
                  if (w_sclk_rise) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                     r_hdr <= w_hdr[HDR_W-2:0];
                     if (r_cnt == CNT_W'(HDR_W - 1)) begin
                        r_state   <= DATA;
                        r_rw      <= w_hdr[HDR_W-1];
                        r_addr    <= w_hdr[ADDR_W-1:0];
                        r_cipo_oe <= ~w_hdr[HDR_W-1];
                        r_tx      <= w_hdr[HDR_W-1] ? '0 : rd_reg(w_hdr[ADDR_W-1:0]);
`ifdef SPI_REG_BANK_BURST_EN
                        r_wcnt    <= '0;
`endif
                     end
                  end
               end else begin
                  if (w_sclk_rise) begin
                     // Saturate so over-length frames can never wrap back to FRAME_W
                     if (r_cnt != CNT_W'(FRAME_W + 1)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                     r_data <= {r_data[DATA_W-2:0], w_copi};
`ifdef SPI_REG_BANK_BURST_EN
                     if (r_wcnt == WCNT_W'(DATA_W - 1)) begin
                        r_wcnt      <= '0;
                        r_word_done <= 1'b1;
                     end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                     end
`endif
                  end
                  // Mode 0: present the next bit on the falling edge
                  if (w_sclk_fall) begin
                     r_cipo <= r_tx[DATA_W-1];
                     r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_flat
         assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
      end
   endgenerate

   assign cipo        = r_cipo;
   assign cipo_oe     = r_cipo_oe;
   assign wr_pulse_o  = r_wr_pulse;
   assign frame_err_o = r_frame_err;
   assign busy_o      = ~w_ncs_sync & (r_state != IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank (default parameters: 8 regs x 8 bits,
// 7-bit address). Table-driven frames plus hand sequences for reset mid-frame
// and (when SPI_REG_BANK_BURST_EN is defined) a two-word burst.
module tb_spi_reg_bank;

   logic        clk;
   logic        rst;
   logic        sclk;
   logic        ncs;
   logic        copi;
   logic        cipo;
   logic        cipo_oe;
   logic [63:0] regs_o;
   logic [7:0]  wr_pulse_o;
   logic        frame_err_o;
   logic        busy_o;

   spi_reg_bank #(
      .NUM_REGS  (8),
      .DATA_W    (8),
      .ADDR_W    (7),
      .RESET_VAL (8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .ncs         (ncs),
      .copi        (copi),
      .cipo        (cipo),
      .cipo_oe     (cipo_oe),
      .regs_o      (regs_o),
      .wr_pulse_o  (wr_pulse_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       err;
      logic [7:0] pulse;
      logic       lat_chk;
   } ev_t;

   typedef struct {
      int         nbits;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
      logic       exp_err;
      logic       exp_wr;
      logic [7:0] exp_rd;
   } vec_t;

   int          n_err = 0;
   int          n_chk = 0;
   ev_t         sb_q[$];
   logic [7:0]  m_regs [8];
   time         t_rise = 0;
   logic [63:0] rx_acc;
   int          oe_bad;
   vec_t        tbl [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_flat();
      logic [63:0] f;
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
      return f;
   endfunction

   function automatic vec_t mk(input int n, input logic rw, input logic [6:0] a, input logic [7:0] d,
                               input logic e_err, input logic e_wr, input logic [7:0] e_rd);
      vec_t v;
      v.nbits = n; v.rw = rw; v.addr = a; v.data = d;
      v.exp_err = e_err; v.exp_wr = e_wr; v.exp_rd = e_rd;
      return v;
   endfunction

   // Scoreboard: every write pulse / error pulse must match the next expected event
   always @(negedge clk) begin
      if (!rst && ((wr_pulse_o != 8'h00) || frame_err_o)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_event", {55'd0, frame_err_o, wr_pulse_o}, 64'd0);
         end else begin
            ev_t e;
            e = sb_q.pop_front();
            check("event", {55'd0, frame_err_o, wr_pulse_o}, {55'd0, e.err, e.pulse});
            if (e.lat_chk) check("latency_le_40ns", 64'(($time - t_rise) <= 40), 64'd1);
         end
      end
   end

   task automatic cs_low();
      ncs = 1'b0;
      #60;
   endtask

   task automatic cs_high();
      #50;
      ncs = 1'b1;
      t_rise = $time;
      #200;
   endtask

   // Send bits k0..k1-1 (MSB-first in bits[63]); sample cipo/cipo_oe at each rise
   task automatic send_bits(input logic [63:0] bits, input int k0, input int k1, input logic rd);
      for (int k = k0; k < k1; k++) begin
         copi = bits[63-k];
         #50;
         sclk = 1'b1;
         rx_acc = {rx_acc[62:0], cipo};
         if (cipo_oe !== ((k >= 8) ? rd : 1'b0)) oe_bad++;
         #50;
         sclk = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [63:0] bits;
      int          n4;
      ev_t         e;
      bits = {v.rw, v.addr, v.data, 48'h0};
      if (v.exp_wr) begin
         m_regs[v.addr[2:0]] = v.data;
         e.err = 1'b0; e.pulse = 8'd1 << v.addr[2:0];
`ifdef SPI_REG_BANK_BURST_EN
         e.lat_chk = 1'b0;
`else
         e.lat_chk = 1'b1;
`endif
         sb_q.push_back(e);
      end
      if (v.exp_err) begin
         e.err = 1'b1; e.pulse = 8'h00; e.lat_chk = 1'b1;
         sb_q.push_back(e);
      end
      rx_acc = '0;
      oe_bad = 0;
      n4 = (v.nbits < 4) ? v.nbits : 4;
      cs_low();
      send_bits(bits, 0, n4, ~v.rw);
      check($sformatf("busy_mid_v%0d", idx), {63'd0, busy_o}, 64'd1);
      send_bits(bits, n4, v.nbits, ~v.rw);
      cs_high();
      check($sformatf("pending_v%0d", idx), 64'(sb_q.size()), 64'd0);
      check($sformatf("regs_v%0d", idx), regs_o, model_flat());
      check($sformatf("cipo_oe_v%0d", idx), 64'(oe_bad), 64'd0);
      check($sformatf("busy_end_v%0d", idx), {63'd0, busy_o}, 64'd0);
      if (!v.rw && (v.nbits == 16)) begin
         check($sformatf("rdata_v%0d", idx), {56'd0, rx_acc[7:0]}, {56'd0, v.exp_rd});
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] bits;
      ev_t         e;
      rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_regs",      regs_o, 64'd0);
      check("rst_wr_pulse",  {56'd0, wr_pulse_o}, 64'd0);
      check("rst_frame_err", {63'd0, frame_err_o}, 64'd0);
      check("rst_busy",      {63'd0, busy_o}, 64'd0);
      check("rst_cipo",      {62'd0, cipo, cipo_oe}, 64'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      //              bits rw addr    data   err   wr    rd
      tbl[0]  = mk(16, 1'b1, 7'h04, 8'hA5, 1'b0, 1'b1, 8'h00);
      tbl[1]  = mk(16, 1'b0, 7'h04, 8'h00, 1'b0, 1'b0, 8'hA5);
      tbl[2]  = mk(15, 1'b1, 7'h02, 8'hFF, 1'b1, 1'b0, 8'h00);
`ifdef SPI_REG_BANK_BURST_EN
      tbl[3]  = mk(17, 1'b1, 7'h02, 8'hFF, 1'b1, 1'b1, 8'h00);
`else
      tbl[3]  = mk(17, 1'b1, 7'h02, 8'hFF, 1'b1, 1'b0, 8'h00);
`endif
      tbl[4]  = mk(16, 1'b1, 7'h7F, 8'h3C, 1'b0, 1'b0, 8'h00);
      tbl[5]  = mk(16, 1'b0, 7'h7F, 8'h00, 1'b0, 1'b0, 8'h00);
      tbl[6]  = mk(16, 1'b1, 7'h00, 8'h5A, 1'b0, 1'b1, 8'h00);
      tbl[7]  = mk(16, 1'b1, 7'h07, 8'hC3, 1'b0, 1'b1, 8'h00);
      tbl[8]  = mk(16, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 8'h5A);
      tbl[9]  = mk(16, 1'b0, 7'h07, 8'h00, 1'b0, 1'b0, 8'hC3);
`ifdef SPI_REG_BANK_BURST_EN
      tbl[10] = mk(16, 1'b0, 7'h02, 8'h00, 1'b0, 1'b0, 8'hFF);
`else
      tbl[10] = mk(16, 1'b0, 7'h02, 8'h00, 1'b0, 1'b0, 8'h00);
`endif
      tbl[11] = mk(16, 1'b1, 7'h08, 8'h99, 1'b0, 1'b0, 8'h00);
      tbl[12] = mk(3,  1'b1, 7'h01, 8'h11, 1'b1, 1'b0, 8'h00);

      for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

      // Reset after 9 bits of a write to reg 1: remainder must be ignored
      bits = {1'b1, 7'h01, 8'h77, 48'h0};
      rx_acc = '0; oe_bad = 0;
      cs_low();
      send_bits(bits, 0, 9, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      #20;
      check("midrst_regs",   regs_o, 64'd0);
      check("midrst_outs",   {59'd0, wr_pulse_o[0], frame_err_o, busy_o, cipo, cipo_oe}, 64'd0);
      check("midrst_pulses", {56'd0, wr_pulse_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      send_bits(bits, 9, 16, 1'b0);
      cs_high();
      check("midrst_no_commit", regs_o, 64'd0);
      check("midrst_pending",   64'(sb_q.size()), 64'd0);
      run_vec(mk(16, 1'b1, 7'h01, 8'h77, 1'b0, 1'b1, 8'h00), 20);

`ifdef SPI_REG_BANK_BURST_EN
      // Two-word burst starting at the last register wraps to reg 0
      bits = {1'b1, 7'h07, 8'h11, 8'h22, 40'h0};
      m_regs[7] = 8'h11;
      m_regs[0] = 8'h22;
      e.err = 1'b0; e.lat_chk = 1'b0;
      e.pulse = 8'h80; sb_q.push_back(e);
      e.pulse = 8'h01; sb_q.push_back(e);
      rx_acc = '0; oe_bad = 0;
      cs_low();
      send_bits(bits, 0, 24, 1'b0);
      cs_high();
      check("burst_pending", 64'(sb_q.size()), 64'd0);
      check("burst_regs",    regs_o, model_flat());
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI (mode 0) register-bank peripheral that succeeds the fixed 5 x 8-bit write-only SPI peripheral. Width, depth and address size are generic. It adds register read-back on CIPO, out-of-range and frame-length error reporting, per-register write strobes and an optional burst mode. It sits between the chip's SPI pins and the PWM/output-enable logic, which consumes the flat register vector.

Parameters:
- NUM_REGS, 8: number of registers; must be ≤ 2**ADDR_W.
- DATA_W, 8: register/data width in bits.
- ADDR_W, 7: address field width.
- RESET_VAL, 0: reset value of every register (DATA_W bits).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- ncs  in  1  SPI chip select, active low, asynchronous.
- copi  in  1  SPI controller-out data, asynchronous.
- cipo  out  1  SPI peripheral-out data.
- cipo_oe  out  1  tri-state enable for cipo.
- regs_o  out  NUM_REGS*DATA_W  flat register contents; reg i occupies [i*DATA_W +: DATA_W].
- wr_pulse_o  out  NUM_REGS  one-clk pulse on bit i when reg i is committed.
- frame_err_o  out  1  one-clk pulse on a malformed frame.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Reset values: regs_o = RESET_VAL in every slot; cipo=0; cipo_oe=0; wr_pulse_o=0; frame_err_o=0; busy_o=0; state=IDLE. Sync flops for ncs reset to 1, for sclk and copi to 0.
- Synchronisation: sclk, ncs and copi each pass through 2 sync flops plus 1 history flop. Edges are detected between sync2 and history. Requirement: f_clk ≥ 8 × f_sclk.
- Frame format (MSB first): rw(1 = write), addr[ADDR_W-1:0], data[DATA_W-1:0]. HDR_W = 1+ADDR_W. FRAME_W = HDR_W+DATA_W.
- States:
  - IDLE: wait for ncs falling edge. On it, clear bit counter and shift register, then go to HDR.
  - HDR: shift copi on each sclk rising edge. After HDR_W bits, latch rw/addr and go to DATA. On a read, load tx_shift with reg[addr], or 0 if addr ≥ NUM_REGS.
  - DATA: shift copi on rising edges. On each sclk falling edge: cipo <= tx_shift MSB, tx_shift <<= 1. cipo_oe = 1 only in DATA with rw=0.
  - Any state on ncs rising edge: evaluate the frame, then return to IDLE.
- Commit (write frame ending at ncs rise with exactly FRAME_W bits and addr < NUM_REGS):
  - reg[addr] <= data and wr_pulse_o[addr]=1, on the clk edge after the edge is detected.
  - Latency: 4 clk from ncs pin rise.
- Bit count ≠ FRAME_W at ncs rise: no commit, frame_err_o pulses 1 clk. This covers both short and long frames.
- Write with addr ≥ NUM_REGS: no commit, no error pulse. A read of such an address returns all zeros.
- sclk edges while ncs_sync high are ignored.
- An ncs falling edge in a non-IDLE state cannot occur (a rising edge always precedes it). A glitch that is shorter than the sync window is absorbed.
- Reset mid-frame: everything returns to reset values. The remainder of the frame is ignored until ncs is seen high then low again.
- The bit counter saturates at FRAME_W+1 so over-length frames never wrap into valid ones.
- busy_o = ncs_sync2 low and state ≠ IDLE.

Optional Feature:
- Macro SPI_REG_BANK_BURST_EN.
- Defined:
  - Each completed DATA_W-bit word in DATA commits immediately, without waiting for ncs, to the current address.
  - The address then increments, wrapping NUM_REGS-1 → 0.
  - A read reloads tx_shift from the next address after each word.
  - At ncs rise, bits in a partial trailing word, or a frame shorter than FRAME_W, give frame_err_o; already-committed words stand.
- Undefined: single-word frames only, as above.

Decomposition:
- Package spi_reg_bank_pkg holds the state enum (IDLE, HDR, DATA) and the localparam helpers HDR_W, FRAME_W and CNT_W = $clog2(FRAME_W+2).
- One natural sub-module: spi_sync_edge, a 2-flop synchroniser plus history flop producing sync, rise and fall. It is instantiated three times.

Test Plan:
1. Write frame rw=1, addr=0x04, data=0xA5 (16 bits) → regs_o slot 4 = 0xA5 within 4 clk of ncs rise, wr_pulse_o=0x10 for 1 clk, other slots unchanged.
2. After test 1, read frame rw=0, addr=0x04 → cipo shows 1010_0101 on the 8 data rising edges, cipo_oe high only in the data phase, no register change.
3. 15-bit write to addr 0x02 with data 0xFF, then a 17-bit write → no commit either time, frame_err_o pulses twice, slot 2 keeps RESET_VAL.
4. Write addr 0x7F (≥ NUM_REGS) data 0x3C → no commit, no error pulse. Read addr 0x7F → cipo all 0.
5. Assert rst after 9 bits of a write to addr 0x01 → all outputs reset. Completing the remaining 7 bits and raising ncs causes no commit. The next full frame commits normally.
6. (BURST_EN) rw=1, addr=NUM_REGS-1, data 0x11, 0x22 → reg[NUM_REGS-1]=0x11 then reg[0]=0x22, two wr_pulse_o pulses, no error.
